quiz_judge_n: RTL and testbench
===============================

// Module: quiz_judge_n
// PURPOSE
//  Parametrised N-player quiz-buzzer judge, the successor of the 4-key judge. Keys are
//  synchronised and edge-detected. The first press after the host arms a round locks out
//  all other players and starts a per-answer countdown. Early presses are flagged as fouls.
//  The block drives active-low player LEDs and an active-low buzzer. It sits between the
//  debounced board keys and the LED/buzzer/7-seg display logic.
// PARAMETERS
//  N_PLAYERS    4         number of contestant keys/LEDs (2..16)
//  TICK_DIV     12000000  clk cycles per 1 s tick (12 MHz board clock)
//  TIMEOUT_SEC  30        answer time in seconds (1..255)
//  BUZZ_CYCLES  6000000   buzzer pulse length in clk cycles (0.5 s)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        synchronous active-low reset
//  host_open    in   1        1-cycle pulse: arm a round (accepted only in IDLE)
//  host_clear   in   1        1-cycle pulse: abort/finish round -> IDLE (any state)
//  key          in   N        raw active-high player keys, asynchronous
//  led_n        out  N        active-low player LEDs
//  winner_idx   out  W        W=$clog2(N_PLAYERS); index of locked/fouling player
//  winner_vld   out  1        high in LOCKED and TIMEOUT
//  foul_vld     out  1        high in FOUL
//  remain_sec   out  8        seconds left; TIMEOUT_SEC while counting starts, 0 on timeout
//  buzz_n       out  1        active-low buzzer
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE; led_n=all 1; winner_idx=0; winner_vld=0;
//    foul_vld=0; remain_sec=0; buzz_n=1; prescaler/buzz counters=0.
//    Both sync stages and the edge-detect register reset to all 1s. A key held through
//    reset therefore produces no rise.
//  - Key path: 2-FF sync -> key_s; rise = key_s & ~key_d. The state/LED update is
//    registered, so an output changes 3 clk after the raw key edge.
//  - Simultaneous rises: the lowest index wins. Rises from other players are ignored.
//  - FSM: IDLE, ARMED, LOCKED, TIMEOUT, FOUL.
//    IDLE:    host_open -> ARMED. Any rise -> FOUL (winner_idx=p, led_n[p]=0, buzz pulse).
//    ARMED:   any rise -> LOCKED (winner_idx=p, led_n[p]=0, remain_sec=TIMEOUT_SEC,
//             prescaler cleared, so the first second is a full TICK_DIV cycles).
//    LOCKED:  each tick decrements remain_sec. At the tick that makes it 0 -> TIMEOUT and
//             start the buzz pulse. Rises are ignored.
//    TIMEOUT: hold led_n and winner_idx; remain_sec=0.
//    FOUL:    hold; host_open ignored.
//    host_clear in any state -> IDLE: led_n all 1, flags 0, remain_sec 0, buzz_n=1 at once.
//  - Same-cycle priority: host_clear > key rise > host_open. Only rising edges count, so a
//    key held across host_open does not lock until it is released and pressed again.
//  - Buzzer: buzz_n=0 for exactly BUZZ_CYCLES clk from entry to FOUL or TIMEOUT, then 1.
//  - Widths: prescaler $clog2(TICK_DIV); buzz counter $clog2(BUZZ_CYCLES+1). No wrap;
//    counters saturate or reload explicitly.
// STRUCTURE
//  - Header quiz_judge_defs.vh: FSM state localparams (3-bit), LED_OFF/LED_ON and
//    BUZZ_OFF/BUZZ_ON levels. The display block reuses these.
//  - One sub-module: key_sync_edge #(WIDTH=N_PLAYERS) (2-FF sync + rise detect,
//    reset-to-1). The FSM, prescaler and buzz timer stay in quiz_judge_n.
// TESTING (N=4, TICK_DIV=4, TIMEOUT_SEC=3, BUZZ_CYCLES=5)
//  1 host_open, then key[2] rises -> 3 clk later led_n=1011, winner_idx=2, winner_vld=1,
//    remain_sec=3. Later key[0] press -> no change.
//  2 Armed, then key[1] and key[3] rise in the same cycle -> winner_idx=1, led_n=1101.
//  3 Locked, no clear -> remain_sec 3,2,1,0 at 4-clk steps; at 0 the state is TIMEOUT
//    and buzz_n=0 for exactly 5 clk.
//  4 IDLE, key[3] press -> foul_vld=1, led_n=0111, 5-clk buzz. host_open ignored.
//    host_clear -> all idle values.
//  5 host_clear and a key rise in the same cycle while ARMED -> IDLE, no lock.
//    Key held through rst_n -> no foul after reset.
//  6 rst_n=0 mid-LOCKED and mid-buzz -> next clk all outputs at reset values, buzz_n=1.

Source files
------------

// File: rtl/quiz_judge_n_pkg.sv
// Shared definitions for the quiz judge: FSM state encoding and the
// active-low LED/buzzer drive levels, reused by the display logic.
package quiz_judge_n_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_FOUL    = 3'd4
    } state_e;

    localparam logic LED_OFF  = 1'b1;
    localparam logic LED_ON   = 1'b0;
    localparam logic BUZZ_OFF = 1'b1;
    localparam logic BUZZ_ON  = 1'b0;

    // Width of a counter/index holding n distinct values, never below 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/quiz_judge_n_key_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for the raw player keys.
// Everything resets to 1 so a key held through reset never looks like a press.
module key_sync_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_key,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_key_d;

    // Synchronise the asynchronous keys and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: resetting to 1, not 0, is what suppresses a fake rise after reset.
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_key_d <= '1;
        end else begin
            // NOTE: non-blocking assignments keep the shift chain one stage per clock.
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_key_d <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_key_d;

endmodule

// File: rtl/quiz_judge_n.sv
// N-player quiz-buzzer judge: first key rise after the host arms a round
// wins and starts the answer countdown; a rise before arming is a foul.
module quiz_judge_n
    import quiz_judge_n_pkg::*;
#(
    parameter int N_PLAYERS   = 4,
    parameter int TICK_DIV    = 12000000,
    parameter int TIMEOUT_SEC = 30,
    parameter int BUZZ_CYCLES = 6000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            host_open,
    input  logic                            host_clear,
    input  logic [N_PLAYERS-1:0]            key,
    output logic [N_PLAYERS-1:0]            led_n,
    output logic [cnt_width(N_PLAYERS)-1:0] winner_idx,
    output logic                            winner_vld,
    output logic                            foul_vld,
    output logic [7:0]                      remain_sec,
    output logic                            buzz_n
);

    localparam int W       = cnt_width(N_PLAYERS);
    localparam int PRESC_W = cnt_width(TICK_DIV);
    localparam int BUZZ_W  = cnt_width(BUZZ_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_LOAD  = BUZZ_W'(BUZZ_CYCLES);
    localparam logic [7:0]         SEC_LOAD   = 8'(TIMEOUT_SEC);

    state_e               r_state;
    logic [N_PLAYERS-1:0] r_led_n;
    logic [W-1:0]         r_winner_idx;
    logic [7:0]           r_remain_sec;
    logic [PRESC_W-1:0]   r_presc;
    logic [BUZZ_W-1:0]    r_buzz_cnt;

    state_e               w_state_next;
    logic [N_PLAYERS-1:0] w_led_next;
    logic [W-1:0]         w_idx_next;
    logic [7:0]           w_remain_next;
    logic [PRESC_W-1:0]   w_presc_next;
    logic [BUZZ_W-1:0]    w_buzz_next;

    logic [N_PLAYERS-1:0] w_rise;
    logic                 w_any_rise;
    logic [W-1:0]         w_rise_idx;
    logic [N_PLAYERS-1:0] w_lock_led;

    key_sync_edge #(.WIDTH(N_PLAYERS)) u_key_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_key  (key),
        .o_rise (w_rise)
    );

    assign w_any_rise = |w_rise;

    // Pick the lowest-index rising key and build its LED pattern.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_rise_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (w_rise[i]) w_rise_idx = W'(i);
        end
        w_lock_led             = {N_PLAYERS{LED_OFF}};
        w_lock_led[w_rise_idx] = LED_ON;
    end

    // Next-state and datapath decisions; host_clear beats a key rise beats host_open.
    always_comb begin
        w_state_next  = r_state;
        w_led_next    = r_led_n;
        w_idx_next    = r_winner_idx;
        w_remain_next = r_remain_sec;
        w_presc_next  = r_presc;
        w_buzz_next   = (r_buzz_cnt != '0) ? r_buzz_cnt - 1'b1 : r_buzz_cnt;

        if (host_clear) begin
            w_state_next  = ST_IDLE;
            w_led_next    = {N_PLAYERS{LED_OFF}};
            w_idx_next    = '0;
            w_remain_next = '0;
            w_presc_next  = '0;
            w_buzz_next   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_rise) begin
                        w_state_next = ST_FOUL;
                        w_led_next   = w_lock_led;
                        w_idx_next   = w_rise_idx;
                        w_buzz_next  = BUZZ_LOAD;
                    end else if (host_open) begin
                        w_state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_any_rise) begin
                        w_state_next  = ST_LOCKED;
                        w_led_next    = w_lock_led;
                        w_idx_next    = w_rise_idx;
                        w_remain_next = SEC_LOAD;
                        w_presc_next  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (r_presc == PRESC_LAST) begin
                        w_presc_next = '0;
                        if (r_remain_sec <= 8'd1) begin
                            w_remain_next = '0;
                            w_state_next  = ST_TIMEOUT;
                            w_buzz_next   = BUZZ_LOAD;
                        end else begin
                            w_remain_next = r_remain_sec - 8'd1;
                        end
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                ST_TIMEOUT: begin
                    w_remain_next = '0;
                end
                ST_FOUL: begin
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_led_next   = {N_PLAYERS{LED_OFF}};
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Registered outputs, countdown prescaler and buzzer timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led_n      <= {N_PLAYERS{LED_OFF}};
            r_winner_idx <= '0;
            r_remain_sec <= '0;
            r_presc      <= '0;
            r_buzz_cnt   <= '0;
        end else begin
            r_led_n      <= w_led_next;
            r_winner_idx <= w_idx_next;
            r_remain_sec <= w_remain_next;
            r_presc      <= w_presc_next;
            r_buzz_cnt   <= w_buzz_next;
        end
    end

    assign led_n      = r_led_n;
    assign winner_idx = r_winner_idx;
    assign winner_vld = (r_state == ST_LOCKED) || (r_state == ST_TIMEOUT);
    assign foul_vld   = (r_state == ST_FOUL);
    assign remain_sec = r_remain_sec;
    assign buzz_n     = (r_buzz_cnt != '0) ? BUZZ_ON : BUZZ_OFF;

endmodule

// File: tb/tb_quiz_judge_n.sv
// Directed bench for quiz_judge_n with N=4, TICK_DIV=4, TIMEOUT_SEC=3, BUZZ_CYCLES=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_quiz_judge_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_open;
    logic       host_clear;
    logic [3:0] key;
    logic [3:0] led_n;
    logic [1:0] winner_idx;
    logic       winner_vld;
    logic       foul_vld;
    logic [7:0] remain_sec;
    logic       buzz_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Packed view of all outputs: led_n, winner_idx, winner_vld, foul_vld, remain_sec, buzz_n.
    localparam logic [16:0] IDLE_OUT = {4'b1111, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1};

    quiz_judge_n #(
        .N_PLAYERS   (4),
        .TICK_DIV    (4),
        .TIMEOUT_SEC (3),
        .BUZZ_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_open  (host_open),
        .host_clear (host_clear),
        .key        (key),
        .led_n      (led_n),
        .winner_idx (winner_idx),
        .winner_vld (winner_vld),
        .foul_vld   (foul_vld),
        .remain_sec (remain_sec),
        .buzz_n     (buzz_n)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] all_out();
        return {led_n, winner_idx, winner_vld, foul_vld, remain_sec, buzz_n};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_open();
        host_open = 1'b1;
        tick(1);
        host_open = 1'b0;
    endtask

    task automatic pulse_clear();
        host_clear = 1'b1;
        tick(1);
        host_clear = 1'b0;
    endtask

    task automatic release_keys();
        key = 4'b0000;
        tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_open = 1'b0; host_clear = 1'b0; key = 4'b0000;
        tick(2);
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", all_out(), IDLE_OUT);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_lock();
        pulse_open();
        key = 4'b0100;
        tick(2);
        n_tests++;
        if (led_n !== 4'b1111) begin
            n_fail++; $display("FAIL lock_latency_early: led_n got %b want 1111", led_n);
        end
        tick(1);
        n_tests++;
        if ({led_n, winner_idx, winner_vld, remain_sec} !== {4'b1011, 2'd2, 1'b1, 8'd3}) begin
            n_fail++; $display("FAIL lock_key2: led=%b idx=%0d vld=%b sec=%0d want 1011/2/1/3",
                               led_n, winner_idx, winner_vld, remain_sec);
        end
        key = 4'b0101;
        tick(4);
        n_tests++;
        if ({led_n, winner_idx, winner_vld, remain_sec} !== {4'b1011, 2'd2, 1'b1, 8'd2}) begin
            n_fail++; $display("FAIL lock_ignore_key0: led=%b idx=%0d vld=%b sec=%0d want 1011/2/1/2",
                               led_n, winner_idx, winner_vld, remain_sec);
        end
        pulse_clear();
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL lock_clear: got %b want %b", all_out(), IDLE_OUT);
        end
        release_keys();
    endtask

    task automatic test_simultaneous();
        pulse_open();
        key = 4'b1010;
        tick(3);
        n_tests++;
        if ({led_n, winner_idx, winner_vld} !== {4'b1101, 2'd1, 1'b1}) begin
            n_fail++; $display("FAIL simultaneous_rise: led=%b idx=%0d vld=%b want 1101/1/1",
                               led_n, winner_idx, winner_vld);
        end
        pulse_clear();
        release_keys();
    endtask

    task automatic test_timeout();
        int low_cnt;
        pulse_open();
        key = 4'b0001;
        tick(3);
        n_tests++;
        if (remain_sec !== 8'd3) begin
            n_fail++; $display("FAIL countdown_start: remain_sec got %0d want 3", remain_sec);
        end
        for (int s = 2; s >= 0; s--) begin
            if (s == 0) tick(3);
            else        tick(4);
            if (s == 0) begin
                n_tests++;
                if (buzz_n !== 1'b1 || remain_sec !== 8'd1) begin
                    n_fail++; $display("FAIL pre_timeout: buzz_n=%b sec=%0d want 1/1", buzz_n, remain_sec);
                end
                tick(1);
            end
            n_tests++;
            if (remain_sec !== 8'(s)) begin
                n_fail++; $display("FAIL countdown_step: remain_sec got %0d want %0d", remain_sec, s);
            end
        end
        n_tests++;
        if ({led_n, winner_idx, winner_vld, foul_vld} !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL timeout_hold: led=%b idx=%0d vld=%b foul=%b want 1110/0/1/0",
                               led_n, winner_idx, winner_vld, foul_vld);
        end
        low_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (buzz_n === 1'b0) low_cnt++;
            tick(1);
        end
        n_tests++;
        if (low_cnt !== 5) begin
            n_fail++; $display("FAIL timeout_buzz_len: low cycles got %0d want 5", low_cnt);
        end
        n_tests++;
        if (remain_sec !== 8'd0 || winner_vld !== 1'b1) begin
            n_fail++; $display("FAIL timeout_stays: sec=%0d vld=%b want 0/1", remain_sec, winner_vld);
        end
        pulse_clear();
        release_keys();
    endtask

    task automatic test_foul();
        int low_cnt;
        key = 4'b1000;
        tick(3);
        n_tests++;
        if ({led_n, winner_idx, winner_vld, foul_vld, buzz_n} !== {4'b0111, 2'd3, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL foul_entry: led=%b idx=%0d vld=%b foul=%b buzz=%b want 0111/3/0/1/0",
                               led_n, winner_idx, winner_vld, foul_vld, buzz_n);
        end
        low_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (buzz_n === 1'b0) low_cnt++;
            tick(1);
        end
        n_tests++;
        if (low_cnt !== 5) begin
            n_fail++; $display("FAIL foul_buzz_len: low cycles got %0d want 5", low_cnt);
        end
        pulse_open();
        tick(1);
        n_tests++;
        if ({foul_vld, winner_vld, led_n} !== {1'b1, 1'b0, 4'b0111}) begin
            n_fail++; $display("FAIL foul_ignores_open: foul=%b vld=%b led=%b want 1/0/0111",
                               foul_vld, winner_vld, led_n);
        end
        pulse_clear();
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL foul_clear: got %b want %b", all_out(), IDLE_OUT);
        end
        release_keys();
    endtask

    task automatic test_clear_priority();
        pulse_open();
        key = 4'b0010;
        tick(2);
        host_clear = 1'b1;
        tick(1);
        host_clear = 1'b0;
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL clear_beats_rise: got %b want %b", all_out(), IDLE_OUT);
        end
        tick(3);
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL clear_no_late_foul: got %b want %b", all_out(), IDLE_OUT);
        end
        release_keys();
    endtask

    task automatic test_held_key();
        rst_n = 1'b0;
        tick(1);
        key = 4'b0100;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL held_through_reset: got %b want %b", all_out(), IDLE_OUT);
        end
        pulse_open();
        tick(3);
        n_tests++;
        if (winner_vld !== 1'b0 || led_n !== 4'b1111) begin
            n_fail++; $display("FAIL held_across_open: vld=%b led=%b want 0/1111", winner_vld, led_n);
        end
        release_keys();
        key = 4'b0100;
        tick(3);
        n_tests++;
        if ({winner_vld, winner_idx, led_n} !== {1'b1, 2'd2, 4'b1011}) begin
            n_fail++; $display("FAIL repress_locks: vld=%b idx=%0d led=%b want 1/2/1011",
                               winner_vld, winner_idx, led_n);
        end
        pulse_clear();
        release_keys();
    endtask

    task automatic test_reset_midrun();
        pulse_open();
        key = 4'b0001;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL reset_mid_locked: got %b want %b", all_out(), IDLE_OUT);
        end
        rst_n = 1'b1;
        release_keys();
        key = 4'b0100;
        tick(5);
        n_tests++;
        if (buzz_n !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_buzz_setup: buzz_n got %b want 0", buzz_n);
        end
        rst_n = 1'b0;
        tick(1);
        n_tests++;
        if (all_out() !== IDLE_OUT) begin
            n_fail++; $display("FAIL reset_mid_buzz: got %b want %b", all_out(), IDLE_OUT);
        end
        rst_n = 1'b1;
        release_keys();
    endtask

    initial begin
        test_reset();
        test_lock();
        test_simultaneous();
        test_timeout();
        test_foul();
        test_clear_priority();
        test_held_key();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
